// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/DM unified-memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DM,
        WAIT_IF
    } arb_state_t;

    // Memory accesses are 8-byte aligned: the low three address bits are dropped.
    localparam logic [63:0] ALIGN_MASK = ~64'h7;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one variable-latency memory between the IF and MEM stages,
// data requests first, with a global stall until every active request is done.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 64,
    parameter int IW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [N-1:0]  if_addr,
    output logic [IW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_read,
    input  logic          dm_write,
    input  logic [N-1:0]  dm_addr,
    input  logic [N-1:0]  dm_wdata,
    output logic [N-1:0]  dm_rdata,
    output logic          dm_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          bus_error
);

    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [N-1:0]  MASK     = N'(ALIGN_MASK);

    arb_state_t    state;
    logic [CW-1:0] cnt;
    logic          dm_act;

    assign dm_act = dm_read | dm_write;
    assign stall  = (dm_act & ~dm_done) | (if_req & ~if_done);

    // Done flags live only for one stall window; clearing them when stall is
    // low takes precedence so a stale completion can never block a new request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dm_act && !dm_done) begin
                        mem_addr  <= dm_addr & MASK;
                        mem_we    <= dm_write;
                        mem_wdata <= dm_wdata;
                        mem_req   <= 1'b1;
                        state     <= WAIT_DM;
                    end else if (if_req && !if_done) begin
                        mem_addr <= if_addr & MASK;
                        mem_we   <= 1'b0;
                        mem_req  <= 1'b1;
                        state    <= WAIT_IF;
                    end
                end
                WAIT_DM, WAIT_IF: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                        if (state == WAIT_DM) begin
                            dm_done <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= if_addr[2] ? mem_rdata[2*IW-1:IW] : mem_rdata[IW-1:0];
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Abandon the access and report zero data so the pipeline can move on.
                        mem_req   <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                        bus_error <= 1'b1;
                        if (state == WAIT_DM) begin
                            dm_done <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= '0;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!stall) begin
                if_done <= 1'b0;
                dm_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_read;
    logic        dm_write;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        bus_error;

    int total = 0;
    int bad   = 0;

    int mem_lat      = 1;
    bit mem_hang     = 1'b0;
    int inject_cycle = -1;
    int cyc          = 0;
    int req_pulses   = 0;

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] exp_rdata;
        logic [63:0] exp_maddr;
        bit          exp_we;
        int          exp_stall;
    } vec_t;

    vec_t vecs[5];

    mem_arbiter #(.N(64), .IW(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_lookup(input logic [63:0] a);
        case (a)
            64'h100: return 64'hAAAA_BBBB_CCCC_DDDD;
            64'h048: return 64'h0123_4567_89AB_CDEF;
            64'h040: return 64'h0000_0000_0000_0055;
            64'h000: return 64'h0000_0000_8B00_0000;
            default: return 64'hDEAD_BEEF_0000_0000 | a;
        endcase
    endfunction

    // Memory model: acks mem_lat cycles after mem_req rises, counts request
    // pulses, and can emit one stray ack at a chosen cycle.
    initial begin
        int  wait_cnt;
        bit  prev_req;
        wait_cnt  = 0;
        prev_req  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_ack = 1'b0;
            if (mem_req && !prev_req) req_pulses++;
            prev_req = mem_req;
            if (mem_req && !mem_hang) begin
                wait_cnt++;
                if (wait_cnt == mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_lookup(mem_addr);
                    wait_cnt  = 0;
                end
            end else begin
                wait_cnt = 0;
            end
            if (cyc == inject_cycle) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one request and follows it until stall releases (bounded).
    task automatic apply_stimulus(input vec_t v, output int stall_cyc, output int req_cyc,
                                  output logic [63:0] cap_addr, output logic cap_we,
                                  output logic [63:0] cap_wdata);
        bit cap;
        @(negedge clk);
        mem_lat = v.lat;
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            dm_read  = !v.wr;
            dm_write = v.wr;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end
        stall_cyc = 0;
        req_cyc   = 0;
        cap       = 1'b0;
        cap_addr  = '0;
        cap_we    = 1'b0;
        cap_wdata = '0;
        #1;
        while (stall && stall_cyc < 50) begin
            stall_cyc++;
            if (mem_req) begin
                req_cyc++;
                if (!cap) begin
                    cap       = 1'b1;
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drop_requests();
        if_req   = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
    endtask

    initial begin
        int          sc, rc, p0, if_cyc, if_cyc_dm_done;
        logic [63:0] ca, cw;
        logic        cwe;
        logic [63:0] first_addr;
        bit          got_first;

        vecs[0] = '{1'b1, 1'b0, 64'h104, 64'h0,    1, 64'hAAAABBBB,            64'h100, 1'b0, 2};
        vecs[1] = '{1'b0, 1'b0, 64'h04D, 64'h0,    2, 64'h0123_4567_89AB_CDEF, 64'h048, 1'b0, 3};
        vecs[2] = '{1'b0, 1'b1, 64'h028, 64'h1234, 3, 64'h0123_4567_89AB_CDEF, 64'h028, 1'b1, 4};
        vecs[3] = '{1'b1, 1'b0, 64'h000, 64'h0,    2, 64'h8B000000,            64'h000, 1'b0, 3};
        vecs[4] = '{1'b1, 1'b0, 64'h04C, 64'h0,    1, 64'h01234567,            64'h048, 1'b0, 2};

        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;

        #2;
        check_output("reset_mem_req",   mem_req,   0);
        check_output("reset_mem_addr",  mem_addr,  0);
        check_output("reset_if_rdata",  if_rdata,  0);
        check_output("reset_dm_rdata",  dm_rdata,  0);
        check_output("reset_bus_error", bus_error, 0);
        check_output("reset_stall",     stall,     0);
        @(negedge clk);
        reset = 1'b0;

        // Reset arriving mid-access must abandon it and ignore a late ack.
        @(negedge clk);
        mem_hang = 1'b1;
        dm_read  = 1'b1;
        dm_addr  = 64'h48;
        @(negedge clk);
        #1;
        check_output("rst_mid_req_up", mem_req, 1);
        #2;
        reset   = 1'b1;
        dm_read = 1'b0;
        #1;
        check_output("rst_mid_req_drop", mem_req, 0);
        check_output("rst_mid_stall",    stall,   0);
        @(negedge clk);
        reset        = 1'b0;
        mem_hang     = 1'b0;
        inject_cycle = cyc + 2;
        repeat (4) @(negedge clk);
        check_output("late_ack_dm_done",  dm_done,  0);
        check_output("late_ack_mem_req",  mem_req,  0);
        check_output("late_ack_dm_rdata", dm_rdata, 0);

        for (int i = 0; i < 5; i++) begin
            p0 = req_pulses;
            apply_stimulus(vecs[i], sc, rc, ca, cwe, cw);
            check_output($sformatf("v%0d_stall_cycles", i), sc,  vecs[i].exp_stall);
            check_output($sformatf("v%0d_req_cycles", i),   rc,  vecs[i].lat);
            check_output($sformatf("v%0d_mem_addr", i),     ca,  vecs[i].exp_maddr);
            check_output($sformatf("v%0d_mem_we", i),       cwe, vecs[i].exp_we);
            if (vecs[i].wr) check_output($sformatf("v%0d_mem_wdata", i), cw, vecs[i].wdata);
            if (vecs[i].is_if) begin
                check_output($sformatf("v%0d_if_done", i),  if_done,  1);
                check_output($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_rdata);
            end else begin
                check_output($sformatf("v%0d_dm_done", i),  dm_done,  1);
                check_output($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].exp_rdata);
            end
            @(negedge clk);
            check_output($sformatf("v%0d_done_cleared", i), {62'b0, if_done, dm_done}, 0);
            check_output($sformatf("v%0d_pulses", i),       req_pulses - p0, 1);
            drop_requests();
        end

        // Both stages request together and hold their requests for the whole window.
        @(negedge clk);
        p0       = req_pulses;
        mem_lat  = 1;
        dm_read  = 1'b1;
        dm_addr  = 64'h40;
        if_req   = 1'b1;
        if_addr  = 64'h0;
        sc = 0;
        if_cyc = 0;
        if_cyc_dm_done = 0;
        got_first  = 1'b0;
        first_addr = '1;
        #1;
        while (stall && sc < 50) begin
            sc++;
            if (mem_req && !got_first) begin
                got_first  = 1'b1;
                first_addr = mem_addr;
            end
            if (mem_req && mem_addr == 64'h0) begin
                if_cyc++;
                if (dm_done) if_cyc_dm_done++;
            end
            @(negedge clk);
            #1;
        end
        check_output("sim_stall_cycles",  sc,             4);
        check_output("sim_first_addr",    first_addr,     64'h40);
        check_output("sim_if_cycles",     if_cyc,         1);
        check_output("sim_dm_done_in_if", if_cyc_dm_done, 1);
        check_output("sim_dm_rdata",      dm_rdata,       64'h55);
        check_output("sim_if_rdata",      if_rdata,       64'h8B000000);
        @(negedge clk);
        check_output("sim_pulses",        req_pulses - p0, 2);
        drop_requests();

        // Unanswered DM read must time out after four wait cycles.
        @(negedge clk);
        mem_hang = 1'b1;
        p0 = req_pulses;
        apply_stimulus('{1'b0, 1'b0, 64'h88, 64'h0, 1, 64'h0, 64'h88, 1'b0, 5}, sc, rc, ca, cwe, cw);
        check_output("to_stall_cycles", sc,        5);
        check_output("to_req_cycles",   rc,        4);
        check_output("to_dm_done",      dm_done,   1);
        check_output("to_dm_rdata",     dm_rdata,  0);
        check_output("to_bus_error",    bus_error, 1);
        @(negedge clk);
        drop_requests();
        mem_hang = 1'b0;

        apply_stimulus(vecs[0], sc, rc, ca, cwe, cw);
        check_output("post_to_if_rdata",  if_rdata,  64'hAAAABBBB);
        check_output("post_to_stall",     sc,        2);
        check_output("post_to_bus_error", bus_error, 1);
        @(negedge clk);
        drop_requests();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
